// File: rtl/amo_pkg.sv
// rtl/amo_pkg.sv - shared types and constants for the RV32A atomic sequencer
package amo_pkg;

    typedef enum logic [3:0] {
        AMO_NONE = 4'd0,
        AMO_LR   = 4'd1,
        AMO_SC   = 4'd2,
        AMO_SWAP = 4'd3,
        AMO_ADD  = 4'd4,
        AMO_XOR  = 4'd5,
        AMO_AND  = 4'd6,
        AMO_OR   = 4'd7,
        AMO_MIN  = 4'd8,
        AMO_MAX  = 4'd9,
        AMO_MINU = 4'd10,
        AMO_MAXU = 4'd11
    } amoop_t;

    typedef enum logic [2:0] {
        S_IDLE,
        S_RD_REQ,
        S_RD_WAIT,
        S_WR_REQ,
        S_DONE
    } amo_state_t;

    localparam int SC_SUCCESS = 0;
    localparam int SC_FAIL    = 1;

endpackage

// File: rtl/amo_alu.sv
// rtl/amo_alu.sv - AMO read-modify-write combine (old, src) -> new; present only with AMO_CTRL_ZAAMO_EN
`ifdef AMO_CTRL_ZAAMO_EN
module amo_alu
    import amo_pkg::*;
#(
    parameter int XLEN    = 32,
    parameter int AMOOP_W = 4
) (
    input  logic [AMOOP_W-1:0] op,
    input  logic [XLEN-1:0]    old_val,
    input  logic [XLEN-1:0]    src_val,
    output logic [XLEN-1:0]    new_val
);

    // Value written back to memory; SWAP (and anything unexpected) stores src
    always_comb begin
        new_val = src_val;
        case (op)
            AMO_ADD:  new_val = old_val + src_val;
            AMO_XOR:  new_val = old_val ^ src_val;
            AMO_AND:  new_val = old_val & src_val;
            AMO_OR:   new_val = old_val | src_val;
            AMO_MIN:  new_val = ($signed(old_val) < $signed(src_val)) ? old_val : src_val;
            AMO_MAX:  new_val = ($signed(old_val) > $signed(src_val)) ? old_val : src_val;
            AMO_MINU: new_val = (old_val < src_val) ? old_val : src_val;
            AMO_MAXU: new_val = (old_val > src_val) ? old_val : src_val;
            default:  new_val = src_val;
        endcase
    end

endmodule
`endif

// File: rtl/amo_ctrl.sv
// rtl/amo_ctrl.sv - RV32A atomic sequencer with LR/SC reservation; AMO_CTRL_ZAAMO_EN enables AMO ops
module amo_ctrl
    import amo_pkg::*;
#(
    parameter int XLEN    = 32,
    parameter int AMOOP_W = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               amo_req_i,
    input  logic [AMOOP_W-1:0] amoop_i,
    input  logic [XLEN-1:0]    addr_i,
    input  logic [XLEN-1:0]    src_i,
    input  logic               st_valid_i,
    input  logic [XLEN-1:0]    st_addr_i,
    input  logic               flush_resv_i,
    output logic               stall_o,
    output logic               done_o,
    output logic               misalign_o,
    output logic               illegal_o,
    output logic [XLEN-1:0]    rd_data_o,
    output logic               dm_req_o,
    output logic               dm_we_o,
    output logic [XLEN-1:0]    dm_addr_o,
    output logic [XLEN-1:0]    dm_wdata_o,
    input  logic               dm_gnt_i,
    input  logic               dm_rvalid_i,
    input  logic [XLEN-1:0]    dm_rdata_i
);

    amo_state_t          state, state_nx;
    logic [AMOOP_W-1:0]  op_q;
    logic [XLEN-1:2]     addr_q;
    logic [XLEN-1:0]     src_q;
    logic [XLEN-1:0]     rd_q;
    logic                mis_q, ill_q;
    logic                resv_valid;
    logic [XLEN-1:2]     resv_addr;

    logic                accept, addr_ok, op_ok, sc_hit;
    logic                resv_clr, resv_set;
    logic [XLEN-1:0]     wdata;
    logic                unused_st_lsbs;

    // Reservation granularity is the word, so store byte offsets never matter
    assign unused_st_lsbs = ^st_addr_i[1:0];

    assign accept  = amo_req_i && (amoop_i != AMO_NONE);
    assign addr_ok = (addr_i[1:0] == 2'b00);
    assign sc_hit  = resv_valid && (addr_i[XLEN-1:2] == resv_addr);

`ifdef AMO_CTRL_ZAAMO_EN
    logic [XLEN-1:0] alu_res;

    // rd_q holds the old memory value between RD_WAIT and the write grant
    amo_alu #(.XLEN(XLEN), .AMOOP_W(AMOOP_W)) u_alu (
        .op      (op_q),
        .old_val (rd_q),
        .src_val (src_q),
        .new_val (alu_res)
    );

    assign op_ok = (amoop_i <= AMO_MAXU);
    assign wdata = (op_q == AMO_SC) ? src_q : alu_res;
`else
    assign op_ok = (amoop_i == AMO_LR) || (amoop_i == AMO_SC);
    assign wdata = src_q;
`endif

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_nx;
    end

    // Next-state decode; requests are only looked at in IDLE
    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE: begin
                if (accept) begin
                    if (!addr_ok || !op_ok)      state_nx = S_DONE;
                    else if (amoop_i == AMO_SC)  state_nx = sc_hit ? S_WR_REQ : S_DONE;
                    else                         state_nx = S_RD_REQ;
                end
            end
            S_RD_REQ:  if (dm_gnt_i) state_nx = S_RD_WAIT;
            S_RD_WAIT: if (dm_rvalid_i) state_nx = (op_q == AMO_LR) ? S_DONE : S_WR_REQ;
            S_WR_REQ:  if (dm_gnt_i) state_nx = S_DONE;
            S_DONE:    state_nx = S_IDLE;
            default:   state_nx = S_IDLE;
        endcase
    end

    // Operand capture, old-value latch and writeback result
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            op_q   <= '0;
            addr_q <= '0;
            src_q  <= '0;
            rd_q   <= '0;
            mis_q  <= 1'b0;
            ill_q  <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (accept) begin
                        op_q   <= amoop_i;
                        addr_q <= addr_i[XLEN-1:2];
                        src_q  <= src_i;
                        mis_q  <= !addr_ok;
                        ill_q  <= addr_ok && !op_ok;
                        if (addr_ok && op_ok && amoop_i == AMO_SC && !sc_hit)
                            rd_q <= XLEN'(SC_FAIL);
                        else
                            rd_q <= '0;
                    end
                end
                S_RD_WAIT: if (dm_rvalid_i) rd_q <= dm_rdata_i;
                S_WR_REQ:  if (dm_gnt_i && op_q == AMO_SC) rd_q <= XLEN'(SC_SUCCESS);
                default: ;
            endcase
        end
    end

    // Reservation: any clear source beats a same-cycle LR set
    assign resv_clr = flush_resv_i
                   || (st_valid_i && st_addr_i[XLEN-1:2] == resv_addr)
                   || (state == S_IDLE && accept && amoop_i == AMO_SC);
    assign resv_set = (state == S_RD_WAIT) && dm_rvalid_i && (op_q == AMO_LR);

    // Reservation register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            resv_valid <= 1'b0;
            resv_addr  <= '0;
        end else if (resv_clr) begin
            resv_valid <= 1'b0;
        end else if (resv_set) begin
            resv_valid <= 1'b1;
            resv_addr  <= addr_q;
        end
    end

    assign stall_o    = amo_req_i && (state != S_DONE);
    assign done_o     = (state == S_DONE);
    assign misalign_o = done_o && mis_q;
    assign illegal_o  = done_o && ill_q;
    assign rd_data_o  = done_o ? rd_q : '0;
    assign dm_req_o   = (state == S_RD_REQ) || (state == S_WR_REQ);
    assign dm_we_o    = (state == S_WR_REQ);
    assign dm_addr_o  = (state != S_IDLE) ? {addr_q, 2'b00} : '0;
    assign dm_wdata_o = dm_we_o ? wdata : '0;

endmodule

// File: tb/tb_amo_ctrl.sv
// tb/tb_amo_ctrl.sv - directed bench for amo_ctrl; expectations follow AMO_CTRL_ZAAMO_EN
module tb_amo_ctrl;
    import amo_pkg::*;

`ifdef AMO_CTRL_ZAAMO_EN
    localparam bit ZA = 1'b1;
`else
    localparam bit ZA = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n, amo_req_i, st_valid_i, flush_resv_i;
    logic [3:0]  amoop_i;
    logic [31:0] addr_i, src_i, st_addr_i;
    logic        stall_o, done_o, misalign_o, illegal_o;
    logic [31:0] rd_data_o;
    logic        dm_req_o, dm_we_o;
    logic [31:0] dm_addr_o, dm_wdata_o;
    logic        dm_gnt_i = 1'b0, dm_rvalid_i = 1'b0;
    logic [31:0] dm_rdata_i = '0;

    int n_tests = 0;
    int n_fail  = 0;

    logic [31:0] mem [0:255];
    int          gnt_delay = 0, rv_lat = 0, wait_cnt = 0, rv_cnt = 0, req_cycles = 0;
    bit          rv_pend = 1'b0;
    logic [31:0] rd_buf, held_addr, held_wdata;
    logic        held_we;

    typedef struct {
        logic [3:0]  op;
        logic [31:0] addr, src, init, exp_rd, exp_mem;
        logic        exp_mis, exp_ill;
        int          exp_stalls, exp_reqs;
    } vec_t;

    localparam int NV = 11;
    vec_t vt [NV];

    always #5 clk = ~clk;

    amo_ctrl dut (
        .clk(clk), .rst_n(rst_n), .amo_req_i(amo_req_i), .amoop_i(amoop_i),
        .addr_i(addr_i), .src_i(src_i), .st_valid_i(st_valid_i), .st_addr_i(st_addr_i),
        .flush_resv_i(flush_resv_i), .stall_o(stall_o), .done_o(done_o),
        .misalign_o(misalign_o), .illegal_o(illegal_o), .rd_data_o(rd_data_o),
        .dm_req_o(dm_req_o), .dm_we_o(dm_we_o), .dm_addr_o(dm_addr_o),
        .dm_wdata_o(dm_wdata_o), .dm_gnt_i(dm_gnt_i), .dm_rvalid_i(dm_rvalid_i),
        .dm_rdata_i(dm_rdata_i)
    );

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endfunction

    // AMO entry: with Zaamo the op reads init, writes nv; without it the op is illegal
    function automatic vec_t mk(input logic [3:0] op, input logic [31:0] a, s, init, nv);
        vec_t v;
        v.op = op; v.addr = a; v.src = s; v.init = init; v.exp_mis = 1'b0;
        v.exp_ill    = !ZA;
        v.exp_rd     = ZA ? init : 32'h0;
        v.exp_mem    = ZA ? nv : init;
        v.exp_stalls = ZA ? 5 : 1;
        v.exp_reqs   = ZA ? 2 : 0;
        return v;
    endfunction

    function automatic vec_t mk_bad(input logic [3:0] op, input logic [31:0] a, input logic mis);
        vec_t v;
        v.op = op; v.addr = a; v.src = 32'h5; v.init = 32'h12345678;
        v.exp_rd = 32'h0; v.exp_mem = 32'h12345678;
        v.exp_mis = mis; v.exp_ill = !mis;
        v.exp_stalls = 1; v.exp_reqs = 0;
        return v;
    endfunction

    // Memory responder: grant after gnt_delay held cycles, rvalid rv_lat cycles after grant
    always @(negedge clk) begin
        dm_gnt_i    = 1'b0;
        dm_rvalid_i = 1'b0;
        if (rv_pend) begin
            if (rv_cnt == 0) begin
                dm_rvalid_i = 1'b1;
                dm_rdata_i  = rd_buf;
                rv_pend     = 1'b0;
            end else begin
                rv_cnt--;
            end
        end
        if (dm_req_o) begin
            req_cycles++;
            if (wait_cnt == 0) begin
                held_addr = dm_addr_o; held_wdata = dm_wdata_o; held_we = dm_we_o;
            end else begin
                chk("hold addr", dm_addr_o, held_addr);
                chk("hold wdata", dm_wdata_o, held_wdata);
                chk("hold we", 32'(dm_we_o), 32'(held_we));
            end
            if (wait_cnt >= gnt_delay) begin
                dm_gnt_i = 1'b1;
                wait_cnt = 0;
                if (dm_we_o) mem[dm_addr_o[9:2]] = dm_wdata_o;
                else begin
                    rv_pend = 1'b1; rv_cnt = rv_lat; rd_buf = mem[dm_addr_o[9:2]];
                end
            end else begin
                wait_cnt++;
            end
        end
    end

    task automatic run_op(input string name, input logic [3:0] op, input logic [31:0] a, s,
                          output logic [31:0] rd, output logic mis, ill, output int stalls, reqs);
        int base;
        bit got = 1'b0;
        rd = '0; mis = 1'b0; ill = 1'b0; stalls = 0;
        @(negedge clk);
        amoop_i = op; addr_i = a; src_i = s; amo_req_i = 1'b1;
        base = req_cycles;
        for (int n = 0; n < 40 && !got; n++) begin
            #1;
            if (done_o) begin
                got = 1'b1;
                rd = rd_data_o; mis = misalign_o; ill = illegal_o;
                if (stall_o) stalls += 100;
                amo_req_i = 1'b0;
            end else begin
                if (stall_o) stalls++;
                @(negedge clk);
            end
        end
        amo_req_i = 1'b0;
        reqs = req_cycles - base;
        chk({name, " done seen"}, 32'(got), 32'd1);
    endtask

    initial begin
        logic [31:0] rd;
        logic        mis, ill;
        int          stalls, reqs, bad;

        rst_n = 1'b0; amo_req_i = 1'b0; amoop_i = '0; addr_i = '0; src_i = '0;
        st_valid_i = 1'b0; st_addr_i = '0; flush_resv_i = 1'b0;
        for (int i = 0; i < 256; i++) mem[i] = '0;

        vt[0]  = mk(AMO_ADD,  32'h100, 32'h1,        32'h7FFFFFFF, 32'h80000000);
        vt[1]  = mk(AMO_MIN,  32'h104, 32'h1,        32'hFFFFFFFF, 32'hFFFFFFFF);
        vt[2]  = mk(AMO_MINU, 32'h108, 32'h1,        32'hFFFFFFFF, 32'h00000001);
        vt[3]  = mk(AMO_OR,   32'h10C, 32'h0000000F, 32'h000000F0, 32'h000000FF);
        vt[4]  = mk(AMO_MAX,  32'h110, 32'h5,        32'h80000000, 32'h00000005);
        vt[5]  = mk(AMO_MAXU, 32'h114, 32'h5,        32'h80000000, 32'h80000000);
        vt[6]  = mk(AMO_XOR,  32'h118, 32'h0FF00FF0, 32'hFF00FF00, 32'hF0F0F0F0);
        vt[7]  = mk(AMO_AND,  32'h11C, 32'h0FF00FF0, 32'hFF00FF00, 32'h0F000F00);
        vt[8]  = mk(AMO_SWAP, 32'h124, 32'h9,        32'h5,        32'h9);
        vt[9]  = mk_bad(AMO_SWAP, 32'h103, 1'b1);
        vt[10] = mk_bad(4'd12,    32'h120, 1'b0);

        repeat (3) @(negedge clk);
        #1;
        chk("reset stall", 32'(stall_o), 32'd0);
        chk("reset done", 32'(done_o), 32'd0);
        chk("reset flags", 32'({misalign_o, illegal_o}), 32'd0);
        chk("reset rd", rd_data_o, 32'd0);
        chk("reset req", 32'({dm_req_o, dm_we_o}), 32'd0);
        chk("reset addr", dm_addr_o, 32'd0);
        chk("reset wdata", dm_wdata_o, 32'd0);
        rst_n = 1'b1;

        // Table: AMO ops, misaligned SWAP, unsupported encoding
        gnt_delay = 0; rv_lat = 1;
        for (int i = 0; i < NV; i++) begin
            mem[vt[i].addr[9:2]] = vt[i].init;
            run_op($sformatf("v%0d", i), vt[i].op, vt[i].addr, vt[i].src, rd, mis, ill, stalls, reqs);
            chk($sformatf("v%0d rd", i), rd, vt[i].exp_rd);
            chk($sformatf("v%0d misalign", i), 32'(mis), 32'(vt[i].exp_mis));
            chk($sformatf("v%0d illegal", i), 32'(ill), 32'(vt[i].exp_ill));
            chk($sformatf("v%0d stalls", i), 32'(stalls), 32'(vt[i].exp_stalls));
            chk($sformatf("v%0d reqs", i), 32'(reqs), 32'(vt[i].exp_reqs));
            chk($sformatf("v%0d mem", i), mem[vt[i].addr[9:2]], vt[i].exp_mem);
        end

        // LR/SC success, then SC without a fresh LR
        rv_lat = 0;
        mem[32'h200 >> 2] = 32'h11;
        run_op("lr1", AMO_LR, 32'h200, 32'h0, rd, mis, ill, stalls, reqs);
        chk("lr1 rd", rd, 32'h11);
        chk("lr1 stalls", 32'(stalls), 32'd3);
        run_op("sc1", AMO_SC, 32'h200, 32'hAB, rd, mis, ill, stalls, reqs);
        chk("sc1 rd", rd, 32'd0);
        chk("sc1 mem", mem[32'h200 >> 2], 32'hAB);
        chk("sc1 stalls", 32'(stalls), 32'd2);
        run_op("sc2", AMO_SC, 32'h200, 32'hCD, rd, mis, ill, stalls, reqs);
        chk("sc2 rd", rd, 32'd1);
        chk("sc2 reqs", 32'(reqs), 32'd0);
        chk("sc2 mem", mem[32'h200 >> 2], 32'hAB);

        // Ordinary store to the reserved word kills the reservation
        run_op("lr2", AMO_LR, 32'h200, 32'h0, rd, mis, ill, stalls, reqs);
        chk("lr2 rd", rd, 32'hAB);
        @(negedge clk); st_valid_i = 1'b1; st_addr_i = 32'h202;
        @(negedge clk); st_valid_i = 1'b0;
        run_op("sc3", AMO_SC, 32'h200, 32'hEE, rd, mis, ill, stalls, reqs);
        chk("sc3 rd", rd, 32'd1);
        chk("sc3 reqs", 32'(reqs), 32'd0);

        // Trap flush kills the reservation
        run_op("lr3", AMO_LR, 32'h200, 32'h0, rd, mis, ill, stalls, reqs);
        @(negedge clk); flush_resv_i = 1'b1;
        @(negedge clk); flush_resv_i = 1'b0;
        run_op("sc4", AMO_SC, 32'h200, 32'hEE, rd, mis, ill, stalls, reqs);
        chk("sc4 rd", rd, 32'd1);
        chk("sc4 mem", mem[32'h200 >> 2], 32'hAB);

        // Grant withheld four cycles on both the read and the write
        gnt_delay = 4;
        mem[32'h204 >> 2] = 32'h77;
        run_op("lr_bp", AMO_LR, 32'h204, 32'h0, rd, mis, ill, stalls, reqs);
        chk("lr_bp rd", rd, 32'h77);
        chk("lr_bp stalls", 32'(stalls), 32'd7);
        run_op("sc_bp", AMO_SC, 32'h204, 32'h55, rd, mis, ill, stalls, reqs);
        chk("sc_bp rd", rd, 32'd0);
        chk("sc_bp stalls", 32'(stalls), 32'd6);
        chk("sc_bp mem", mem[32'h204 >> 2], 32'h55);
        gnt_delay = 0;

        // Reset while waiting for read data; the late rvalid must be ignored
        rv_lat = 3;
        mem[32'h208 >> 2] = 32'hCAFE;
        @(negedge clk); amoop_i = AMO_LR; addr_i = 32'h208; amo_req_i = 1'b1;
        @(negedge clk);
        @(negedge clk); #1;
        chk("rdwait req/stall", 32'({dm_req_o, stall_o}), 32'b01);
        rst_n = 1'b0; amo_req_i = 1'b0;
        @(negedge clk); #1;
        chk("rst mid stall", 32'(stall_o), 32'd0);
        chk("rst mid done", 32'(done_o), 32'd0);
        chk("rst mid req", 32'(dm_req_o), 32'd0);
        chk("rst mid rd", rd_data_o, 32'd0);
        rst_n = 1'b1;
        bad = 0;
        repeat (5) begin
            @(negedge clk); #1;
            if (done_o || dm_req_o || stall_o) bad++;
        end
        chk("late rvalid ignored", 32'(bad), 32'd0);
        rv_lat = 0;
        run_op("sc_rst", AMO_SC, 32'h208, 32'h1, rd, mis, ill, stalls, reqs);
        chk("sc after rst rd", rd, 32'd1);
        chk("sc after rst mem", mem[32'h208 >> 2], 32'hCAFE);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/amo_ctrl.md
Name: amo_ctrl

Overview:
- Multi-cycle sequencer for RV32A atomics, sitting in the memory stage beside the LSU.
- Takes an AMO or LR/SC op from the EX/MEM register and stalls the pipeline while it runs.
- Runs a read-modify-write on the data-memory port and returns the rd writeback value.
- Owns the single LR/SC reservation register.

Parameters:
- XLEN, 32, data/address width.
- AMOOP_W, 4, width of amoop_t.

Ports:
- clk  in  1  clock.
- rst_n  in  1  synchronous active-low reset.
- amo_req_i  in  1  atomic op present in the memory stage.
- amoop_i  in  AMOOP_W  op: NONE, LR, SC, SWAP, ADD, XOR, AND, OR, MIN, MAX, MINU, MAXU.
- addr_i  in  XLEN  effective address (rs1).
- src_i  in  XLEN  rs2 value.
- st_valid_i  in  1  ordinary store committed this cycle.
- st_addr_i  in  XLEN  address of that store.
- flush_resv_i  in  1  trap/xRET; invalidates the reservation.
- stall_o  out  1  holds IF..MEM.
- done_o  out  1  one-cycle completion pulse.
- misalign_o  out  1  one-cycle pulse with done_o on misaligned address.
- illegal_o  out  1  one-cycle pulse with done_o on unsupported op.
- rd_data_o  out  XLEN  writeback value, valid while done_o.
- dm_req_o  out  1  memory request.
- dm_we_o  out  1  write enable.
- dm_addr_o  out  XLEN  word address (bits [1:0] = 0).
- dm_wdata_o  out  XLEN  write data.
- dm_gnt_i  in  1  request accepted.
- dm_rvalid_i  in  1  read data valid.
- dm_rdata_i  in  XLEN  read data.

Behaviour:
- Reset (rst_n low at a clk edge):
  - state IDLE, resv_valid 0, resv_addr 0.
  - All outputs 0.
  - Any outstanding read response is dropped; dm_rvalid_i is ignored outside RD_WAIT.
- States and transitions:
  - IDLE: on amo_req_i with amoop_i != NONE, latch amoop, addr, src.
    - addr[1:0] != 0: go to DONE with misalign_o=1, rd_data_o=0, no memory access.
    - LR or AMO: go to RD_REQ.
    - SC with resv_valid and addr[31:2]==resv_addr[31:2]: go to WR_REQ.
    - SC otherwise: go to DONE with rd_data_o=1.
    - Every SC clears resv_valid on leaving IDLE.
  - RD_REQ: dm_req_o=1, dm_we_o=0. Held until dm_gnt_i, then RD_WAIT.
  - RD_WAIT: wait for dm_rvalid_i and latch rdata as old value.
    - LR: set resv_valid, resv_addr=addr, rd_data=old, go to DONE.
    - AMO: rd_data=old, go to WR_REQ.
  - WR_REQ: dm_req_o=1, dm_we_o=1. dm_wdata_o = src for SC, amo_alu(op, old, src) for AMO. On dm_gnt_i go to DONE; SC sets rd_data=0.
  - DONE: done_o=1, stall_o=0, rd_data_o valid. Always go to IDLE next cycle; the pipeline advances on this edge.
- stall_o = amo_req_i and state != DONE, including the IDLE cycle of acceptance (combinational from amo_req_i).
- dm_addr_o = {addr[31:2], 2'b00} for the whole op. Request signals stay stable until grant.
- Arithmetic, all on XLEN bits:
  - ADD wraps modulo 2^32.
  - MIN/MAX use signed compare; MINU/MAXU use unsigned compare.
  - SWAP writes src.
- Reservation:
  - Cleared when st_valid_i and st_addr_i[31:2]==resv_addr[31:2], or when flush_resv_i is high.
  - If a clear and the LR set happen in the same cycle, the clear wins.
  - The SC check samples the registered resv_valid.
- A new op is never accepted in DONE; amo_req_i is ignored in every state other than IDLE.

Optional Feature:
- Macro: AMO_CTRL_ZAAMO_EN.
- Defined: full A extension; all AMO ops execute as above.
- Undefined: Zalrsc only; amo_alu is not instantiated.
  - AMO ops go IDLE to DONE with illegal_o=1, rd_data_o=0, no memory access.
  - LR/SC behave unchanged.

Decomposition:
- amo_pkg:
  - amoop_t enum with fixed encoding (NONE=0, LR=1, SC=2, SWAP=3, ADD=4, XOR=5, AND=6, OR=7, MIN=8, MAX=9, MINU=10, MAXU=11).
  - amo_state_t (IDLE, RD_REQ, RD_WAIT, WR_REQ, DONE).
  - SC_SUCCESS=0 and SC_FAIL=1 constants.
- Sub-module amo_alu: combinational (op, old, src) -> new value.

Test Plan:
- AMOADD: mem[0x100]=0x7FFFFFFF, src=1, gnt immediate, rvalid 1 cycle later -> mem 0x80000000, rd_data_o=0x7FFFFFFF, stall 5 cycles, done_o 1 pulse.
- AMOMIN vs AMOMINU: old=0xFFFFFFFF, src=1 -> MIN writes 0xFFFFFFFF; MINU writes 0x00000001; rd_data_o=0xFFFFFFFF in both cases.
- LR/SC pairs:
  - LR 0x200, then SC 0x200 src=0xAB -> mem=0xAB, rd_data_o=0.
  - A second SC with no new LR -> rd_data_o=1, no dm_req_o.
- LR 0x200, store to 0x202 (st_valid_i), SC 0x200 -> rd_data_o=1. Repeat with flush_resv_i instead of the store -> same result.
- Misaligned AMOSWAP at 0x103 -> misalign_o with done_o on the 2nd cycle, no dm_req_o.
- Backpressure and reset:
  - dm_gnt_i withheld 4 cycles -> dm_req_o, dm_addr_o, dm_wdata_o held stable throughout.
  - rst_n low in RD_WAIT -> next cycle IDLE, outputs 0; a late rvalid is ignored.
  - With AMO_CTRL_ZAAMO_EN undefined, AMOOR -> illegal_o pulse, no dm_req_o.
